// File: rtl/tmds_decoder_dvi_rx.sv
// Receive-side TMDS channel decoder with control-token word alignment for one DVI colour channel.
// Optional TMDS_DECODER_ERROR_COUNT_EN adds a saturating counter of encoder-choice violations while locked.
module tmds_decoder_dvi_rx #(
    parameter int TOKEN_RUN   = 8,
    parameter int TIMEOUT     = 2048,
    parameter int SLIP_SETTLE = 4
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [9:0]  symbol_i,
    output logic [7:0]  data_o,
    output logic [1:0]  ctrl_o,
    output logic        de_o,
    output logic        aligned_o,
    output logic        bitslip_o
`ifdef TMDS_DECODER_ERROR_COUNT_EN
    ,
    output logic [15:0] error_count_o
`endif
);

    localparam int RUN_W = $clog2(TOKEN_RUN + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int SET_W = $clog2(SLIP_SETTLE + 1);

    typedef enum logic [1:0] {SEARCH, SLIP, LOCKED} state_t;

    state_t             state;
    logic [9:0]         sym_q;
    logic [RUN_W-1:0]   run_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic               is_token;
    logic [1:0]         token_ctrl;
    logic [7:0]         v;
    logic [7:0]         dec;
    logic               qual;
    logic               tmo_expired;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) sym_q <= '0;
        else            sym_q <= symbol_i;
    end

    always_comb begin
        is_token   = 1'b1;
        token_ctrl = 2'b00;
        case (sym_q)
            10'b1101010100: token_ctrl = 2'b00;
            10'b0010101011: token_ctrl = 2'b01;
            10'b0101010100: token_ctrl = 2'b10;
            10'b1010101011: token_ctrl = 2'b11;
            default:        is_token   = 1'b0;
        endcase
    end

    // Undo the optional DC-balance inversion, then the XOR/XNOR transition chain.
    always_comb begin
        v      = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
        dec    = '0;
        dec[0] = v[0];
        for (int i = 1; i < 8; i++)
            dec[i] = sym_q[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_o <= '0;
            ctrl_o <= '0;
            de_o   <= 1'b0;
        end else if (is_token) begin
            data_o <= '0;
            ctrl_o <= token_ctrl;
            de_o   <= 1'b0;
        end else begin
            data_o <= dec;
            de_o   <= 1'b1;
        end
    end

    assign qual        = is_token && (run_cnt == RUN_W'(TOKEN_RUN - 1));
    assign tmo_expired = (tmo_cnt == TMO_W'(TIMEOUT));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)                       run_cnt <= '0;
        else if (state == SLIP || !is_token)  run_cnt <= '0;
        else if (run_cnt != RUN_W'(TOKEN_RUN)) run_cnt <= run_cnt + RUN_W'(1);
    end

    // A qualifying run is checked before the timeout so a tie locks instead of slipping.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= SEARCH;
            tmo_cnt    <= '0;
            settle_cnt <= '0;
            aligned_o  <= 1'b0;
            bitslip_o  <= 1'b0;
        end else begin
            bitslip_o <= 1'b0;
            case (state)
                SEARCH: begin
                    if (qual) begin
                        state     <= LOCKED;
                        aligned_o <= 1'b1;
                        tmo_cnt   <= '0;
                    end else if (tmo_expired) begin
                        state      <= SLIP;
                        bitslip_o  <= 1'b1;
                        settle_cnt <= '0;
                        tmo_cnt    <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                SLIP: begin
                    if (settle_cnt == SET_W'(SLIP_SETTLE - 1)) begin
                        state   <= SEARCH;
                        tmo_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                LOCKED: begin
                    if (qual) begin
                        tmo_cnt <= '0;
                    end else if (tmo_expired) begin
                        state     <= SEARCH;
                        aligned_o <= 1'b0;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: begin
                    state     <= SEARCH;
                    tmo_cnt   <= '0;
                    aligned_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef TMDS_DECODER_ERROR_COUNT_EN
    logic [3:0] n1;
    logic       xnor_expected;
    logic       choice_bad;

    // The transmitter's XOR/XNOR choice is a function of the byte, so bit 8 must agree with it.
    always_comb begin
        n1            = 4'($countones(dec));
        xnor_expected = (n1 > 4'd4) || (n1 == 4'd4 && !dec[0]);
        choice_bad    = (sym_q[8] == xnor_expected);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            error_count_o <= '0;
        else if (state == LOCKED && !is_token && choice_bad && error_count_o != 16'hFFFF)
            error_count_o <= error_count_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_tmds_decoder_dvi_rx.sv
// Directed self-checking bench for tmds_decoder_dvi_rx: alignment, decode, timeouts and reset.
// Error-counter checks are compiled only when TMDS_DECODER_ERROR_COUNT_EN is defined.
module tb_tmds_decoder_dvi_rx;

    localparam logic [9:0] TOK0 = 10'b1101010100;
    localparam logic [9:0] TOK1 = 10'b0010101011;
    localparam logic [9:0] TOK2 = 10'b0101010100;
    localparam logic [9:0] TOK3 = 10'b1010101011;
    localparam logic [9:0] DATA_A5 = 10'h163;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [9:0]  symbol_i;
    logic [7:0]  data_o;
    logic [1:0]  ctrl_o;
    logic        de_o;
    logic        aligned_o;
    logic        bitslip_o;
`ifdef TMDS_DECODER_ERROR_COUNT_EN
    logic [15:0] error_count_o;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    logic prev_slip = 1'b0;

    tmds_decoder_dvi_rx dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .symbol_i      (symbol_i),
        .data_o        (data_o),
        .ctrl_o        (ctrl_o),
        .de_o          (de_o),
        .aligned_o     (aligned_o),
        .bitslip_o     (bitslip_o)
`ifdef TMDS_DECODER_ERROR_COUNT_EN
        ,
        .error_count_o (error_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Drive the symbol sampled at the next rising edge, then return at the following falling edge.
    task automatic applyStimulus(input logic [9:0] sym);
        symbol_i = sym;
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic doReset();
        reset_n_i = 1'b0;
        symbol_i  = 10'h000;
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        cyc = 0;
    endtask

    // Token 00 as seen by a deserializer whose word boundary is off by 'off' bits.
    function automatic logic [9:0] rotSym(input int off);
        logic [9:0] t;
        logic [9:0] r;
        t = TOK0;
        r = '0;
        for (int k = 0; k < 10; k++) r[k] = t[(k + off) % 10];
        return r;
    endfunction

    always @(negedge clk_i) begin
        if (bitslip_o) begin
            checkOutput("slip_not_back_to_back", 32'(prev_slip), 32'd0);
            checkOutput("slip_never_locked", 32'(aligned_o), 32'd0);
        end
        prev_slip = bitslip_o;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] syms  [4];
        logic [7:0] bytes [4];
        int slips, off, npulse, lock_cyc, found;
        int pulse_cyc [3];

        reset_n_i = 1'b1;
        symbol_i  = 10'h000;
        #2 reset_n_i = 1'b0;
        #1;
        checkOutput("reset_data", 32'(data_o), 32'd0);
        checkOutput("reset_ctrl", 32'(ctrl_o), 32'd0);
        checkOutput("reset_de", 32'(de_o), 32'd0);
        checkOutput("reset_aligned", 32'(aligned_o), 32'd0);
        checkOutput("reset_bitslip", 32'(bitslip_o), 32'd0);
`ifdef TMDS_DECODER_ERROR_COUNT_EN
        checkOutput("reset_errcnt", 32'(error_count_o), 32'd0);
`endif

        $display("[TB] aligned token stream");
        doReset();
        slips = 0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(TOK0);
            if (bitslip_o) slips++;
            if (i == 8) checkOutput("t1_not_yet_aligned", 32'(aligned_o), 32'd0);
            if (i == 9) checkOutput("t1_aligned", 32'(aligned_o), 32'd1);
        end
        checkOutput("t1_ctrl", 32'(ctrl_o), 32'd0);
        checkOutput("t1_de", 32'(de_o), 32'd0);
        checkOutput("t1_data", 32'(data_o), 32'd0);
        checkOutput("t1_no_slip", 32'(slips), 32'd0);
        applyStimulus(TOK1);
        applyStimulus(TOK2);
        checkOutput("t1_ctrl01", 32'(ctrl_o), 32'd1);
        applyStimulus(TOK3);
        checkOutput("t1_ctrl10", 32'(ctrl_o), 32'd2);
        applyStimulus(TOK3);
        checkOutput("t1_ctrl11", 32'(ctrl_o), 32'd3);

        $display("[TB] data decode after lock");
        syms  = '{10'h100, 10'h200, 10'h163, 10'h241};
        bytes = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
        for (int k = 0; k <= 4; k++) begin
            applyStimulus(k < 4 ? syms[k] : TOK1);
            if (k > 0) begin
                checkOutput("t2_data", 32'(data_o), 32'(bytes[k-1]));
                checkOutput("t2_de", 32'(de_o), 32'd1);
                checkOutput("t2_ctrl_hold", 32'(ctrl_o), 32'd3);
            end
        end
        applyStimulus(TOK1);
        checkOutput("t2_token_de", 32'(de_o), 32'd0);
        checkOutput("t2_token_data", 32'(data_o), 32'd0);
        checkOutput("t2_token_ctrl", 32'(ctrl_o), 32'd1);
`ifdef TMDS_DECODER_ERROR_COUNT_EN
        checkOutput("t2_errcnt_clean", 32'(error_count_o), 32'd0);
`endif

        $display("[TB] lock loss and re-lock");
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(TOK0);
        for (int j = 9; j <= 2058; j++) begin
            applyStimulus(DATA_A5);
            if (j == 2057) checkOutput("t4_still_locked", 32'(aligned_o), 32'd1);
            if (j == 2058) checkOutput("t4_lock_lost", 32'(aligned_o), 32'd0);
        end
        found = 0;
        for (int i = 0; i < 7; i++) begin applyStimulus(TOK0); if (aligned_o) found = 1; end
        for (int i = 0; i < 20; i++) begin applyStimulus(DATA_A5); if (aligned_o) found = 1; end
        checkOutput("t4_seven_no_relock", 32'(found), 32'd0);
        for (int i = 0; i < 8; i++) applyStimulus(TOK0);
        checkOutput("t4_eight_not_yet", 32'(aligned_o), 32'd0);
        applyStimulus(DATA_A5);
        checkOutput("t4_relock", 32'(aligned_o), 32'd1);

        $display("[TB] rotated stream with slip model");
        doReset();
        off = 7;
        npulse = 0;
        lock_cyc = 0;
        pulse_cyc = '{0, 0, 0};
        while (cyc < 6300 && lock_cyc == 0) begin
            applyStimulus(rotSym(off));
            if (bitslip_o) begin
                if (npulse < 3) pulse_cyc[npulse] = cyc;
                npulse++;
                off = (off + 1) % 10;
            end
            if (aligned_o) lock_cyc = cyc;
        end
        checkOutput("t3_pulse_count", 32'(npulse), 32'd3);
        checkOutput("t3_pulse1", 32'(pulse_cyc[0]), 32'd2049);
        checkOutput("t3_pulse2", 32'(pulse_cyc[1]), 32'd4102);
        checkOutput("t3_pulse3", 32'(pulse_cyc[2]), 32'd6155);
        checkOutput("t3_lock_cycle", 32'(lock_cyc), 32'd6167);

        $display("[TB] run completing on timeout cycle");
        doReset();
        slips = 0;
        for (int i = 0; i < 2040; i++) begin applyStimulus(DATA_A5); if (bitslip_o) slips++; end
        for (int i = 0; i < 8; i++) begin applyStimulus(TOK0); if (bitslip_o) slips++; end
        applyStimulus(TOK0);
        if (bitslip_o) slips++;
        checkOutput("t5_tie_locks", 32'(aligned_o), 32'd1);
        checkOutput("t5_tie_no_slip", 32'(slips), 32'd0);
        doReset();
        for (int i = 0; i < 2041; i++) applyStimulus(DATA_A5);
        for (int i = 0; i < 8; i++) applyStimulus(TOK0);
        checkOutput("t5_late_slips", 32'(bitslip_o), 32'd1);
        checkOutput("t5_late_unlocked", 32'(aligned_o), 32'd0);

`ifdef TMDS_DECODER_ERROR_COUNT_EN
        $display("[TB] encoder-choice error counting");
        // A lone bit-8 flip of a valid symbol decodes to a byte that still agrees with its flag,
        // so these symbols carry a flag that contradicts their decoded byte instead.
        doReset();
        applyStimulus(10'h155);
        for (int i = 0; i < 8; i++) applyStimulus(TOK0);
        applyStimulus(10'h155);
        applyStimulus(10'h0AA);
        checkOutput("t6_bad_data", 32'(data_o), 32'hFF);
        applyStimulus(10'h355);
        applyStimulus(10'h2AA);
        applyStimulus(10'h115);
        applyStimulus(DATA_A5);
        checkOutput("t6_errcnt", 32'(error_count_o), 32'd5);
        checkOutput("t6_last_data", 32'(data_o), 32'h3F);
`endif

        $display("[TB] reset during slip pulse");
        applyStimulus(TOK3);
        found = 0;
        for (int i = 0; i < 5000 && found == 0; i++) begin
            applyStimulus(DATA_A5);
            if (bitslip_o) found = 1;
        end
        checkOutput("t7_slip_seen", 32'(found), 32'd1);
`ifdef TMDS_DECODER_ERROR_COUNT_EN
        checkOutput("t7_errcnt_kept", 32'(error_count_o), 32'd5);
`endif
        checkOutput("t7_pre_data", 32'(data_o), 32'hA5);
        reset_n_i = 1'b0;
        #1;
        checkOutput("t7_bitslip", 32'(bitslip_o), 32'd0);
        checkOutput("t7_aligned", 32'(aligned_o), 32'd0);
        checkOutput("t7_data", 32'(data_o), 32'd0);
        checkOutput("t7_de", 32'(de_o), 32'd0);
        checkOutput("t7_ctrl", 32'(ctrl_o), 32'd0);
`ifdef TMDS_DECODER_ERROR_COUNT_EN
        checkOutput("t7_errcnt", 32'(error_count_o), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
